// File: rtl/sram_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bus_arbiter_if
//  Description : Request/response bundle for the instruction, data and memory
//                sides of the SRAM-like split-transaction bus arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sram_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction side (read-only)
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    // Data side
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [3:0]        data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    // Memory side
    logic              mem_req;
    logic              mem_wr;
    logic [1:0]        mem_size;
    logic [3:0]        mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_addr_ok;
    logic              mem_data_ok;
    logic [DATA_W-1:0] mem_rdata;

    // The arbiter itself
    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    // The pipeline requesters together with the memory bridge
    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bus_arbiter
//  Description : Fixed-priority (data over inst) arbiter onto one SRAM-like
//                port, with an in-order tag FIFO routing responses back.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_bus_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  wire logic                               clk,
    input  wire logic                               resetn,
    sram_bus_arbiter_if.slave                       bus,
    output logic [$clog2(MAX_OUTSTANDING):0]        outstanding,
    output logic                                    resp_err
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [MAX_OUTSTANDING-1:0] r_tags;
    logic [PTR_W-1:0]           r_wr_ptr;
    logic [PTR_W-1:0]           r_rd_ptr;
    logic [CNT_W-1:0]           r_count;
    logic                       r_resp_err;

    logic w_full;
    logic w_empty;
    logic w_sel_data;
    logic w_push;
    logic w_pop;
    logic w_head;

    assign w_full     = (r_count == c_MAX_CNT);
    assign w_empty    = (r_count == '0);
    assign w_sel_data = bus.data_req;
    assign w_head     = r_tags[r_rd_ptr];

    always_comb begin
        bus.mem_req      = (bus.inst_req | bus.data_req) & ~w_full;
        bus.mem_wr       = 1'b0;
        bus.mem_size     = 2'd2;
        bus.mem_wstrb    = 4'h0;
        bus.mem_addr     = ADDR_W'(bus.inst_addr);
        bus.mem_wdata    = DATA_W'(0);
        bus.inst_addr_ok = 1'b0;
        bus.data_addr_ok = 1'b0;

        if (w_sel_data) begin
            bus.mem_wr    = bus.data_wr;
            bus.mem_size  = bus.data_size;
            bus.mem_wstrb = bus.data_wstrb;
            bus.mem_addr  = bus.data_addr;
            bus.mem_wdata = bus.data_wdata;
        end

        w_push           = bus.mem_req & bus.mem_addr_ok;
        bus.data_addr_ok = w_push & w_sel_data;
        bus.inst_addr_ok = w_push & ~w_sel_data;

        // A response with nothing outstanding is dropped and flagged instead
        w_pop            = bus.mem_data_ok & ~w_empty;
        bus.data_data_ok = w_pop & w_head;
        bus.inst_data_ok = w_pop & ~w_head;
        bus.inst_rdata   = bus.mem_rdata;
        bus.data_rdata   = bus.mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_resp_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_tags[r_wr_ptr] <= w_sel_data;
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (bus.mem_data_ok && w_empty) begin
                r_resp_err <= 1'b1;
            end
        end
    end

    assign outstanding = r_count;
    assign resp_err    = r_resp_err;
endmodule
`default_nettype wire

// File: tb/tb_sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_bus_arbiter
//  Description : Directed and random-traffic self-checking bench for
//                sram_bus_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_bus_arbiter;
    localparam int MAX_OUTSTANDING = 2;

    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] outstanding;
    logic       resp_err;
    int         n_vec = 0;
    int         n_err = 0;

    sram_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    sram_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) dut (
        .clk(clk), .resetn(resetn), .bus(bus),
        .outstanding(outstanding), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.inst_req    = 1'b0;
        bus.inst_addr   = '0;
        bus.data_req    = 1'b0;
        bus.data_wr     = 1'b0;
        bus.data_size   = 2'd0;
        bus.data_wstrb  = 4'h0;
        bus.data_addr   = '0;
        bus.data_wdata  = '0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = '0;
    endtask

    bit q[$];

    initial begin
        idle();
        resetn = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        #1;
        chk("rst_outstanding", outstanding, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_addr_ok", {bus.inst_addr_ok, bus.data_addr_ok}, 0);
        chk("rst_data_ok", {bus.inst_data_ok, bus.data_data_ok}, 0);

        // Single instruction read
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1c00_0000; bus.mem_addr_ok = 1'b1;
        #1;
        chk("inst_mem_req", bus.mem_req, 1);
        chk("inst_mem_addr", bus.mem_addr, 64'h1c00_0000);
        chk("inst_mem_wr", bus.mem_wr, 0);
        chk("inst_mem_size", bus.mem_size, 2);
        chk("inst_addr_ok", bus.inst_addr_ok, 1);
        chk("inst_no_data_addr_ok", bus.data_addr_ok, 0);
        tick();
        chk("inst_outstanding1", outstanding, 1);
        idle();
        bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h0280_0000;
        #1;
        chk("inst_data_ok", bus.inst_data_ok, 1);
        chk("inst_no_data_data_ok", bus.data_data_ok, 0);
        chk("inst_rdata", bus.inst_rdata, 64'h0280_0000);
        tick();
        chk("inst_outstanding0", outstanding, 0);

        // Conflict: data wins, inst follows next cycle
        idle();
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1c00_0004;
        bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_size = 2'd2;
        bus.data_addr = 32'h10; bus.data_wstrb = 4'hf; bus.data_wdata = 32'hdead_beef;
        bus.mem_addr_ok = 1'b1;
        #1;
        chk("cf_mem_wr", bus.mem_wr, 1);
        chk("cf_mem_addr", bus.mem_addr, 64'h10);
        chk("cf_mem_wstrb", bus.mem_wstrb, 4'hf);
        chk("cf_mem_wdata", bus.mem_wdata, 64'hdead_beef);
        chk("cf_data_addr_ok", bus.data_addr_ok, 1);
        chk("cf_inst_addr_ok", bus.inst_addr_ok, 0);
        tick();
        bus.data_req = 1'b0;
        #1;
        chk("cf2_inst_addr_ok", bus.inst_addr_ok, 1);
        chk("cf2_mem_addr", bus.mem_addr, 64'h1c00_0004);
        chk("cf2_mem_wr", bus.mem_wr, 0);
        chk("cf2_mem_wstrb", bus.mem_wstrb, 0);
        chk("cf2_mem_wdata", bus.mem_wdata, 0);
        tick();

        // Full: requests blocked, a response does not bypass in the same cycle
        chk("full_outstanding", outstanding, 2);
        chk("full_mem_req", bus.mem_req, 0);
        chk("full_inst_addr_ok", bus.inst_addr_ok, 0);
        bus.mem_data_ok = 1'b1;
        #1;
        chk("full_pop_data_ok", bus.data_data_ok, 1);
        chk("full_pop_inst_ok", bus.inst_data_ok, 0);
        chk("full_no_bypass", bus.mem_req, 0);
        tick();
        chk("full_after_pop", outstanding, 1);
        chk("full_mem_req_again", bus.mem_req, 1);

        // Push and pop together at outstanding = 1
        #1;
        chk("pp_inst_addr_ok", bus.inst_addr_ok, 1);
        chk("pp_inst_data_ok", bus.inst_data_ok, 1);
        tick();
        chk("pp_outstanding", outstanding, 1);
        idle();
        bus.mem_data_ok = 1'b1;
        #1;
        chk("pp_drain_inst_ok", bus.inst_data_ok, 1);
        tick();
        chk("pp_drained", outstanding, 0);

        // Interleaved order: data read then inst read
        idle();
        bus.data_req = 1'b1; bus.data_addr = 32'h20; bus.mem_addr_ok = 1'b1;
        tick();
        bus.data_req = 1'b0; bus.inst_req = 1'b1; bus.inst_addr = 32'h1c00_0008;
        tick();
        chk("il_outstanding", outstanding, 2);
        idle();
        bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h1234_5678;
        #1;
        chk("il_first_data_ok", {bus.data_data_ok, bus.inst_data_ok}, 2'b10);
        chk("il_data_rdata", bus.data_rdata, 64'h1234_5678);
        tick();
        bus.mem_rdata = 32'h9abc_def0;
        #1;
        chk("il_second_inst_ok", {bus.data_data_ok, bus.inst_data_ok}, 2'b01);
        chk("il_inst_rdata", bus.inst_rdata, 64'h9abc_def0);
        tick();
        chk("il_drained", outstanding, 0);

        // Random traffic against an in-order reference queue
        idle();
        for (int i = 0; i < 100; i++) begin
            logic ir, dr, aok, dok, exp_req, push, pop, head;
            ir  = 1'($urandom_range(0, 1));
            dr  = 1'($urandom_range(0, 1));
            aok = 1'($urandom_range(0, 1));
            dok = (q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.inst_req = ir; bus.data_req = dr;
            bus.mem_addr_ok = aok; bus.mem_data_ok = dok;
            exp_req = (ir | dr) && (q.size() < MAX_OUTSTANDING);
            push = exp_req & aok;
            pop  = dok && (q.size() > 0);
            head = (q.size() > 0) ? q[0] : 1'b0;
            #1;
            chk("rnd_mem_req", bus.mem_req, exp_req);
            chk("rnd_addr_ok", {bus.data_addr_ok, bus.inst_addr_ok},
                {push & dr, push & ~dr});
            chk("rnd_data_ok", {bus.data_data_ok, bus.inst_data_ok},
                {pop & head, pop & ~head});
            if (pop) void'(q.pop_front());
            if (push) q.push_back(dr);
            tick();
            chk("rnd_outstanding", outstanding, q.size());
        end
        idle();

        // Spurious response with nothing outstanding
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        bus.mem_data_ok = 1'b1;
        #1;
        chk("sp_no_data_ok", {bus.data_data_ok, bus.inst_data_ok}, 0);
        tick();
        bus.mem_data_ok = 1'b0;
        chk("sp_resp_err", resp_err, 1);
        chk("sp_outstanding", outstanding, 0);
        tick(); tick();
        chk("sp_resp_err_held", resp_err, 1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("sp_rst_resp_err", resp_err, 0);
        chk("sp_rst_outstanding", outstanding, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Two-requester arbiter that shares one SRAM-like memory port between the instruction-fetch side and the data-access side of the CPU pipeline. Each requester and the memory port use a req / addr_ok / data_ok split-transaction handshake. The block selects one requester per cycle with fixed data-over-instruction priority. It tracks up to MAX_OUTSTANDING accepted transactions in an in-order tag FIFO and routes each memory response back to the requester that issued it. It sits between the IF/MEM pipeline stages and the memory bridge.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transactions (power of two, ≥2)

- clk  in  1  clock, all state on rising edge
- resetn  in  1  synchronous active-low reset
- inst_req  in  1  instruction read request (read-only side)
- inst_addr  in  ADDR_W  instruction address
- inst_addr_ok  out  1  instruction request accepted this cycle
- inst_data_ok  out  1  instruction read data valid this cycle
- inst_rdata  out  DATA_W  instruction read data
- data_req  in  1  data request
- data_wr  in  1  1 = write, 0 = read
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_wstrb  in  4  write byte strobes
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  write data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  data response (read data or write ack) this cycle
- data_rdata  out  DATA_W  data read data
- mem_req  out  1  request to memory
- mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/2/4/ADDR_W/DATA_W  forwarded request fields
- mem_addr_ok  in  1  memory accepted request
- mem_data_ok  in  1  memory response valid
- mem_rdata  in  DATA_W  memory read data
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  current count of unanswered transactions
- resp_err  out  1  sticky: mem_data_ok seen with no outstanding transaction

## Operation
- Grant is combinational:
  - sel_data = data_req.
  - sel_inst = inst_req & ~data_req.
- mem_req = (inst_req | data_req) & ~full, where full = (outstanding == MAX_OUTSTANDING).
- mem_* request fields come from the selected requester.
- For an inst grant: mem_wr = 0, mem_size = 2, mem_wstrb = 0, mem_wdata = 0.
- Handshake (accept) = mem_req & mem_addr_ok.
  - Only the selected requester sees addr_ok = 1.
  - The other requester sees 0 and must hold its request stable.
- On accept: push a 1-bit tag into the FIFO (1 = data, 0 = inst).
- On mem_data_ok with FIFO non-empty: pop the head tag.
  - Head tag 1 → data_data_ok = 1.
  - Head tag 0 → inst_data_ok = 1.
  - At most one data_ok output is high per cycle.
- inst_rdata and data_rdata both carry mem_rdata unconditionally; they are valid only with their own data_ok.
- Simultaneous push and pop: both take effect; outstanding is unchanged; FIFO pointers wrap modulo MAX_OUTSTANDING.
- Pop and push in the same cycle while full: push is blocked, because mem_req is already 0 combinationally. No same-cycle bypass.
- mem_data_ok while empty: no data_ok output, no pop, resp_err set to 1. resp_err stays set until reset.
- No ordering check between an outstanding data write and an instruction read to the same address; the memory side preserves order.

## Timing
- Reset (resetn = 0 at a clock edge): FIFO pointers and outstanding cleared to 0, resp_err cleared to 0.
- Combinational outputs follow the inputs after reset:
  - mem_req = 0 when neither side requests.
  - All addr_ok/data_ok = 0 unless driven by mem_* inputs.
- Request path (req → mem_req → addr_ok) is fully combinational, 0 cycles.
- Response routing is combinational from mem_data_ok and the registered head tag.
  - Earliest response is the cycle after accept (count becomes 1 at that edge).
  - A response in the accept cycle itself is a protocol violation; it is handled as the empty case.
- Back-to-back accepts are allowed every cycle until full.
- The inst side may starve under continuous data_req; this is accepted by design, because the pipeline stalls data requests itself.
- Reset mid-transaction drops all tags. The memory side shares resetn, so no stale responses follow.

## Test plan
- Single inst read: inst_req = 1, inst_addr = 0x1c000000, mem_addr_ok = 1 → mem_addr = 0x1c000000, inst_addr_ok = 1, outstanding = 1. Next cycle mem_data_ok = 1, mem_rdata = 0x02800000 → inst_data_ok = 1, inst_rdata = 0x02800000, outstanding = 0.
- Conflict: inst_req and data_req (wr = 1, addr 0x10, wstrb 0xF, wdata 0xDEADBEEF) both high → mem_wr = 1, mem_addr = 0x10, data_addr_ok = 1, inst_addr_ok = 0. Next cycle the inst request is granted.
- Full: two accepts with no response → outstanding = 2, mem_req = 0 with inst_req = 1, and no addr_ok. One mem_data_ok → mem_req = 1 again in the following cycle.
- Interleaved order: accept data read, then inst read; two mem_data_ok pulses → first data_data_ok, then inst_data_ok. No cross-routing.
- Simultaneous push/pop at outstanding = 1: accept plus mem_data_ok in the same cycle → outstanding stays 1. 100-cycle random traffic → FIFO wraps correctly and response order matches issue order.
- Spurious response: mem_data_ok = 1 with outstanding = 0 → no data_ok output, resp_err = 1 and held; resetn = 0 for one cycle → resp_err = 0, outstanding = 0.
